// File: rtl/display_pkg.sv
// Shared display-path constants: pixel clock, image count defaults
// and the key/vsync polarities used by the LCD driver and pattern path.
package display_pkg;

  localparam int PCLK_HZ = 70_000_000;
  localparam int DEF_NUM_IMG = 8;
  localparam int DEF_DEBOUNCE = PCLK_HZ / 100;
  localparam int DEF_AUTO_FRAMES = 120;
  localparam bit BTN_ACTIVE_LOW = 1'b1;
  localparam bit VS_ACTIVE_LOW = 1'b1;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_CHK,
    DB_HELD,
    DB_REL_CHK
  } db_state_t;

  function automatic int img_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Board key conditioner: 2-FF synchronizer and a press/release
// debounce FSM emitting a single press pulse per debounced press.
module btn_debounce
  import display_pkg::*;
#(
  parameter int CYCLES = DEF_DEBOUNCE,
  parameter bit ACTIVE_LOW = BTN_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic sync1;
  logic sync2;
  logic lvl;
  db_state_t state;
  db_state_t state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
      state <= DB_IDLE;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // lvl is 1 whenever the key is held, whatever the pin polarity
  assign lvl = sync2 ^ ACTIVE_LOW;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    unique case (state)
      DB_IDLE: begin
        if (lvl) begin
          state_nxt = DB_PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      DB_PRESS_CHK: begin
        if (!lvl) begin
          state_nxt = DB_IDLE;
        end else if (cnt == CNT_MAX) begin
          state_nxt = DB_HELD;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DB_HELD: begin
        if (!lvl) begin
          state_nxt = DB_REL_CHK;
          cnt_nxt   = '0;
        end
      end
      DB_REL_CHK: begin
        if (lvl) begin
          state_nxt = DB_HELD;
        end else if (cnt == CNT_MAX) begin
          state_nxt = DB_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = DB_IDLE;
    endcase
  end

endmodule

// File: rtl/img_sequencer.sv
// Frame-synchronous image scheduler: key or auto advances are latched
// and applied only at the vsync frame start.
module img_sequencer
  import display_pkg::*;
#(
  parameter int NUM_IMG = DEF_NUM_IMG,
  parameter int IMG_W = img_w(NUM_IMG),
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int AUTO_FRAMES = DEF_AUTO_FRAMES,
  parameter bit BTN_ACTIVE_LOW = display_pkg::BTN_ACTIVE_LOW,
  parameter bit VS_ACTIVE_LOW = display_pkg::VS_ACTIVE_LOW
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             btn_next_img,
  input  logic             auto_en,
  input  logic             vs,
  output logic [IMG_W-1:0] img_sel,
  output logic             img_changed,
  output logic             adv_pending,
  output logic [15:0]      frame_cnt
);

  localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(NUM_IMG - 1);
  localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);

  logic press;
  logic vs_a;
  logic vs_q;
  logic fs;
  logic tick;
  logic adv;
  logic [15:0] auto_cnt;

  btn_debounce #(
    .CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW(BTN_ACTIVE_LOW)
  ) u_debounce (
    .clk(pclk),
    .rst_n(rst_n),
    .btn(btn_next_img),
    .press(press)
  );

  assign vs_a = vs ^ VS_ACTIVE_LOW;
  assign fs   = vs_a & ~vs_q;
  assign tick = fs & auto_en & (auto_cnt == AUTO_LAST);
  // press, pending and tick all merge into at most one advance per frame
  assign adv  = adv_pending | press | tick;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      img_sel     <= '0;
      img_changed <= 1'b0;
      adv_pending <= 1'b0;
      frame_cnt   <= '0;
      auto_cnt    <= '0;
    end else begin
      vs_q        <= vs_a;
      img_changed <= 1'b0;
      if (fs) begin
        frame_cnt   <= frame_cnt + 16'd1;
        adv_pending <= 1'b0;
        if (adv) begin
          img_sel     <= (img_sel == IMG_LAST) ? '0 : img_sel + IMG_W'(1);
          img_changed <= 1'b1;
        end
      end else if (press) begin
        adv_pending <= 1'b1;
      end
      if (!auto_en || (fs && adv)) begin
        auto_cnt <= '0;
      end else if (fs) begin
        auto_cnt <= auto_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_img_sequencer.sv
// Randomised and directed bench for img_sequencer with a
// run-length debounce model and frame-level scheduling model.
module tb_img_sequencer;

  localparam int NI = 4;
  localparam int IW = 2;
  localparam int DEB = 4;
  localparam int AF = 3;
  localparam int FL = 50;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b1;
  logic auto_en = 1'b0;
  logic vs = 1'b1;
  logic [IW-1:0] img_sel;
  logic img_changed;
  logic adv_pending;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;

  img_sequencer #(
    .NUM_IMG(NI),
    .IMG_W(IW),
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_FRAMES(AF),
    .BTN_ACTIVE_LOW(1'b1),
    .VS_ACTIVE_LOW(1'b1)
  ) dut (
    .pclk(pclk),
    .rst_n(rst_n),
    .btn_next_img(btn),
    .auto_en(auto_en),
    .vs(vs),
    .img_sel(img_sel),
    .img_changed(img_changed),
    .adv_pending(adv_pending),
    .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  // vsync: low for the first 2 cycles of every 50-cycle frame
  bit vs_run = 1'b0;
  int vpos = 0;
  always @(negedge pclk) begin
    if (!vs_run) begin
      vs = 1'b1;
      vpos = 0;
    end else begin
      vs = (vpos < 2) ? 1'b0 : 1'b1;
      vpos = (vpos == FL - 1) ? 0 : vpos + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: key is debounced as "level differs from the
  // debounced level for DEB+1 consecutive synchronized samples".
  logic m_s1 = 1'b1;
  logic m_s2 = 1'b1;
  bit m_db, m_vsq, m_pend, m_chg, m_ok;
  int m_run, m_img, m_acnt, m_fcnt;
  int n_press = 0;

  always @(posedge pclk) begin : model
    bit p, f, tk, adv, pr;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_db = 0; m_run = 0; m_vsq = 0;
      m_pend = 0; m_chg = 0; m_img = 0;
      m_acnt = 0; m_fcnt = 0;
    end else begin
      p = !m_s2;
      m_s2 = m_s1;
      m_s1 = btn;
      pr = 0;
      if (p != m_db) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_db = p;
          m_run = 0;
          pr = p;
        end
      end else begin
        m_run = 0;
      end
      f = !vs && !m_vsq;
      m_vsq = !vs;
      tk = f && auto_en && (m_acnt == AF - 1);
      adv = m_pend || pr || tk;
      m_chg = 0;
      if (f) begin
        m_fcnt = (m_fcnt + 1) % 65536;
        m_pend = 0;
        if (adv) begin
          m_img = (m_img + 1) % NI;
          m_chg = 1;
        end
      end else if (pr) begin
        m_pend = 1;
      end
      if (!auto_en || (f && adv)) m_acnt = 0;
      else if (f) m_acnt++;
      if (pr) n_press++;
    end
    m_ok = 1;
  end

  int n_chg = 0;
  always @(negedge pclk) begin
    if (m_ok) begin
      chk("img_sel", img_sel, m_img);
      chk("img_changed", img_changed, m_chg);
      chk("adv_pending", adv_pending, m_pend);
      chk("frame_cnt", frame_cnt, m_fcnt);
    end
    if (img_changed === 1'b1) n_chg++;
  end

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic wait_pos(input int k);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (vpos != k && n < 2 * FL);
    if (vpos != k) chk("wait_pos", vpos, k);
  endtask

  task automatic press_frame(input int hold);
    wait_pos(10);
    btn = 1'b0;
    repeat (hold) step();
    btn = 1'b1;
    wait_pos(5);
  endtask

  task automatic rand_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      if ($urandom_range(0, 40) == 0) auto_en = ~auto_en;
      step();
    end
    btn = 1'b1;
    auto_en = 1'b0;
    repeat (12) step();
  endtask

  int c0;
  int p0;

  initial begin
    repeat (3) step();
    chk("rst_img", img_sel, 0);
    chk("rst_chg", img_changed, 0);
    chk("rst_pend", adv_pending, 0);
    chk("rst_fcnt", frame_cnt, 0);
    rst_n = 1'b1;
    vs_run = 1'b1;
    wait_pos(5);

    c0 = n_chg;
    p0 = n_press;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      repeat (2) step();
    end
    btn = 1'b0;
    repeat (10) step();
    btn = 1'b1;
    chk("bounce_press", n_press - p0, 1);
    chk("bounce_hold", img_sel, 0);
    wait_pos(5);
    chk("bounce_img", img_sel, 1);
    chk("bounce_pulse", n_chg - c0, 1);

    wait_pos(10);
    btn = 1'b0;
    repeat (10) step();
    btn = 1'b1;
    chk("mid_pend", adv_pending, 1);
    chk("mid_hold", img_sel, 1);
    wait_pos(5);
    chk("mid_img", img_sel, 2);
    chk("mid_clear", adv_pending, 0);

    press_frame(10);
    chk("wrap_3", img_sel, 3);
    press_frame(10);
    chk("wrap_0", img_sel, 0);

    auto_en = 1'b1;
    wait_pos(5);
    wait_pos(5);
    chk("auto_hold", img_sel, 0);
    wait_pos(5);
    chk("auto_adv", img_sel, 1);
    press_frame(10);
    chk("auto_manual", img_sel, 2);
    wait_pos(5);
    wait_pos(5);
    chk("auto_wait", img_sel, 2);
    wait_pos(5);
    chk("auto_restart", img_sel, 3);

    wait_pos(5);
    wait_pos(5);
    chk("coll_hold", img_sel, 3);
    c0 = n_chg;
    press_frame(10);
    chk("coll_img", img_sel, 0);
    chk("coll_pulse", n_chg - c0, 1);

    auto_en = 1'b0;
    rand_phase(1500);

    vs_run = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    vs_run = 1'b1;
    press_frame(10);
    press_frame(10);
    repeat (4) wait_pos(5);
    wait_pos(10);
    btn = 1'b0;
    repeat (10) step();
    chk("pre_img", img_sel, 2);
    chk("pre_pend", adv_pending, 1);
    chk("pre_fcnt", frame_cnt, 7);
    rst_n = 1'b0;
    btn = 1'b1;
    step();
    chk("mrst_img", img_sel, 0);
    chk("mrst_pend", adv_pending, 0);
    chk("mrst_fcnt", frame_cnt, 0);
    chk("mrst_chg", img_changed, 0);
    rst_n = 1'b1;
    wait_pos(5);
    wait_pos(5);
    chk("post_img", img_sel, 0);
    chk("post_pend", adv_pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
